// File: rtl/mem_bus_arbiter_if.sv
// Memory bus side of mem_bus_arbiter: request fields out, grant and responses in.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic                  bus_req_o;
  logic                  bus_we_o;
  logic [ADDR_W-1:0]     bus_addr_o;
  logic [DATA_W-1:0]     bus_wdata_o;
  logic [DATA_W/8-1:0]   bus_wstrb_o;
  logic                  bus_gnt_i;
  logic                  bus_rvalid_i;
  logic [DATA_W-1:0]     bus_rdata_i;
  logic                  bus_bvalid_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wstrb_o,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_bvalid_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wstrb_o,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_bvalid_i
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between IF (read-only) and LS, one transaction at a time.
// Define ARB_FAIR_EN for alternating priority; default is fixed LS-over-IF priority.
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_rvalid_o,
  input  logic                ls_req_i,
  input  logic                ls_we_i,
  input  logic [ADDR_W-1:0]   ls_addr_i,
  input  logic [DATA_W-1:0]   ls_wdata_i,
  input  logic [DATA_W/8-1:0] ls_wstrb_i,
  output logic [DATA_W-1:0]   ls_rdata_o,
  output logic                ls_done_o,
  mem_bus_arbiter_if.master   bus,
  output logic                ram_stall_valid_if_o,
  output logic                ram_stall_valid_mem_o
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;   // 1 = LS, 0 = IF
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                bus_req_q, bus_req_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic                ls_done_q, ls_done_d;
  logic                ls_wins;
  logic                resp_hit;

  always_comb begin
`ifdef ARB_FAIR_EN
    // owner_q doubles as history: on a tie the last owner yields
    ls_wins = ls_req_i & (~if_req_i | ~owner_q);
`else
    ls_wins = ls_req_i;
`endif
    resp_hit    = we_q ? bus.bus_bvalid_i : bus.bus_rvalid_i;
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    data_d      = data_q;
    bus_req_d   = 1'b0;
    if_rvalid_d = 1'b0;
    ls_done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req_i | ls_req_i) begin
          owner_d   = ls_wins;
          state_d   = REQ;
          bus_req_d = 1'b1;
          if (ls_wins) begin
            we_d    = ls_we_i;
            addr_d  = ls_addr_i;
            wdata_d = ls_wdata_i;
            wstrb_d = ls_wstrb_i;
          end else begin
            we_d    = 1'b0;
            addr_d  = if_addr_i;
            wdata_d = '0;
            wstrb_d = '0;
          end
        end
      end
      REQ: begin
        if (bus.bus_gnt_i) state_d = RESP;
        else               bus_req_d = 1'b1;
      end
      RESP: begin
        if (resp_hit) begin
          if (!we_q) data_d = bus.bus_rdata_i;
          state_d     = DONE;
          if_rvalid_d = ~owner_q;
          ls_done_d   = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      data_q      <= '0;
      bus_req_q   <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      data_q      <= data_d;
      bus_req_q   <= bus_req_d;
      if_rvalid_q <= if_rvalid_d;
      ls_done_q   <= ls_done_d;
    end
  end

  assign bus.bus_req_o   = bus_req_q;
  assign bus.bus_we_o    = we_q;
  assign bus.bus_addr_o  = addr_q;
  assign bus.bus_wdata_o = wdata_q;
  assign bus.bus_wstrb_o = wstrb_q;
  assign if_rdata_o      = data_q;
  assign ls_rdata_o      = data_q;
  assign if_rvalid_o     = if_rvalid_q;
  assign ls_done_o       = ls_done_q;

  assign ram_stall_valid_if_o  = if_req_i & ~if_rvalid_q;
  assign ram_stall_valid_mem_o = ls_req_i & ~ls_done_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a randomized
// run against a transaction-level model (owner order, memory contents, latency).
module tb_mem_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = DW / 8;
`ifdef ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_i, ls_req_i, ls_we_i;
  logic [AW-1:0] if_addr_i, ls_addr_i;
  logic [DW-1:0] ls_wdata_i, if_rdata_o, ls_rdata_o;
  logic [SW-1:0] ls_wstrb_i;
  logic          if_rvalid_o, ls_done_o, stall_if, stall_mem;

  mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_rvalid_o(if_rvalid_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i),
    .ls_wstrb_i(ls_wstrb_i), .ls_rdata_o(ls_rdata_o), .ls_done_o(ls_done_o),
    .bus(bus.master),
    .ram_stall_valid_if_o(stall_if), .ram_stall_valid_mem_o(stall_mem)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_req_i = 0; if_addr_i = '0; ls_req_i = 0; ls_we_i = 0; ls_addr_i = '0;
    ls_wdata_i = '0; ls_wstrb_i = '0;
    bus.bus_gnt_i = 0; bus.bus_rvalid_i = 0; bus.bus_bvalid_i = 0; bus.bus_rdata_i = '0;
  endtask

  // Plays the bus for one transaction with no extra delays; returns in the DONE cycle.
  task automatic serve(input logic [DW-1:0] rd, output logic [AW-1:0] a, output bit ok);
    ok = 0; a = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.bus_req_o) begin ok = 1; break; end
    end
    if (!ok) return;
    a = bus.bus_addr_o;
    bus.bus_gnt_i = 1;
    tick();
    bus.bus_gnt_i = 0;
    if (bus.bus_we_o) bus.bus_bvalid_i = 1;
    else begin bus.bus_rvalid_i = 1; bus.bus_rdata_i = rd; end
    tick();
    bus.bus_rvalid_i = 0; bus.bus_bvalid_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; if_req_i = 1; ls_req_i = 1;
    repeat (2) tick();
    checks++;
    if ({bus.bus_req_o, bus.bus_we_o, if_rvalid_o, ls_done_o} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000", {bus.bus_req_o, bus.bus_we_o, if_rvalid_o, ls_done_o});
    end
    checks++;
    if ({if_rdata_o, ls_rdata_o, bus.bus_addr_o, bus.bus_wstrb_o} !== '0) begin
      errors++; $display("FAIL reset_data: got if_rdata=%h addr=%h want 0", if_rdata_o, bus.bus_addr_o);
    end
    checks++;
    if ({stall_if, stall_mem} !== 2'b11) begin
      errors++; $display("FAIL reset_stall_follow: got %b want 11", {stall_if, stall_mem});
    end
    if_req_i = 0; ls_req_i = 0; #1;
    checks++;
    if ({stall_if, stall_mem} !== 2'b00) begin
      errors++; $display("FAIL reset_stall_low: got %b want 00", {stall_if, stall_mem});
    end
    rst = 0;
  endtask

  task automatic test_if_read();
    logic [DW-1:0] d = 64'h0000_0013_0000_0093;
    tick();
    if_req_i = 1; if_addr_i = 32'h8000_0000; #1;
    checks++;
    if ({stall_if, bus.bus_req_o} !== 2'b10) begin
      errors++; $display("FAIL ifrd_c0: stall/req got %b want 10", {stall_if, bus.bus_req_o});
    end
    tick();
    checks++;
    if ({bus.bus_req_o, bus.bus_we_o, bus.bus_addr_o, bus.bus_wstrb_o, stall_if} !== {2'b10, 32'h8000_0000, 8'h00, 1'b1}) begin
      errors++; $display("FAIL ifrd_c1: req=%b we=%b addr=%h strb=%h want 1 0 80000000 00", bus.bus_req_o, bus.bus_we_o, bus.bus_addr_o, bus.bus_wstrb_o);
    end
    bus.bus_gnt_i = 1;
    tick();
    bus.bus_gnt_i = 0;
    checks++;
    if ({bus.bus_req_o, if_rvalid_o, stall_if} !== 3'b001) begin
      errors++; $display("FAIL ifrd_c2: req/rvalid/stall got %b want 001", {bus.bus_req_o, if_rvalid_o, stall_if});
    end
    bus.bus_rvalid_i = 1; bus.bus_rdata_i = d;
    tick();
    bus.bus_rvalid_i = 0; bus.bus_rdata_i = '0;
    checks++;
    if ({if_rvalid_o, ls_done_o, stall_if, if_rdata_o} !== {3'b100, d}) begin
      errors++; $display("FAIL ifrd_c3: rvalid=%b done=%b stall=%b data=%h want 1 0 0 %h", if_rvalid_o, ls_done_o, stall_if, if_rdata_o, d);
    end
    if_req_i = 0;
    tick();
    checks++;
    if ({if_rvalid_o, if_rdata_o} !== {1'b0, d}) begin
      errors++; $display("FAIL ifrd_c4: rvalid=%b data=%h want 0 %h", if_rvalid_o, if_rdata_o, d);
    end
  endtask

  task automatic test_ls_write();
    logic [DW-1:0] prev = if_rdata_o;
    tick();
    ls_req_i = 1; ls_we_i = 1; ls_addr_i = 32'h8000_1000; ls_wdata_i = 64'hDEAD_BEEF; ls_wstrb_i = 8'h0F;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({bus.bus_req_o, bus.bus_we_o, bus.bus_addr_o, bus.bus_wdata_o, bus.bus_wstrb_o} !== {2'b11, 32'h8000_1000, 64'hDEAD_BEEF, 8'h0F}) begin
        errors++; $display("FAIL lswr_req%0d: req=%b we=%b addr=%h wdata=%h strb=%h", i, bus.bus_req_o, bus.bus_we_o, bus.bus_addr_o, bus.bus_wdata_o, bus.bus_wstrb_o);
      end
      bus.bus_gnt_i = (i == 3);
    end
    tick();
    bus.bus_gnt_i = 0;
    tick();
    checks++;
    if ({bus.bus_req_o, ls_done_o, stall_mem} !== 3'b001) begin
      errors++; $display("FAIL lswr_resp_wait: req/done/stall got %b want 001", {bus.bus_req_o, ls_done_o, stall_mem});
    end
    bus.bus_bvalid_i = 1; bus.bus_rdata_i = 64'h5555_5555_5555_5555;
    tick();
    bus.bus_bvalid_i = 0;
    checks++;
    if ({ls_done_o, if_rvalid_o, stall_mem, ls_rdata_o} !== {3'b100, prev}) begin
      errors++; $display("FAIL lswr_done: done=%b stall=%b rdata=%h want 1 0 %h", ls_done_o, stall_mem, ls_rdata_o, prev);
    end
    idle_inputs();
    tick();
    checks++;
    if (ls_done_o !== 1'b0) begin
      errors++; $display("FAIL lswr_pulse_len: done=%b want 0", ls_done_o);
    end
  endtask

  task automatic test_simultaneous();
    bit first_ls = !FAIR;   // last owner is LS here, so fair mode hands IF the tie
    logic [AW-1:0] a; bit ok;
    tick();
    if_req_i = 1; if_addr_i = 32'h8000_0100;
    ls_req_i = 1; ls_we_i = 0; ls_addr_i = 32'h8000_0200;
    serve(64'hAAAA_0000_AAAA_0001, a, ok);
    checks++;
    if (!ok || a !== (first_ls ? 32'h8000_0200 : 32'h8000_0100)) begin
      errors++; $display("FAIL sim_first_addr: ok=%b addr=%h want %h", ok, a, first_ls ? 32'h8000_0200 : 32'h8000_0100);
    end
    checks++;
    if ({ls_done_o, if_rvalid_o, first_ls ? stall_if : stall_mem, ls_rdata_o} !== {first_ls, !first_ls, 1'b1, 64'hAAAA_0000_AAAA_0001}) begin
      errors++; $display("FAIL sim_first_done: ls_done=%b if_rvalid=%b loser_stall=%b data=%h", ls_done_o, if_rvalid_o, first_ls ? stall_if : stall_mem, ls_rdata_o);
    end
    if (first_ls) ls_req_i = 0; else if_req_i = 0;
    serve(64'hBBBB_0000_BBBB_0002, a, ok);
    checks++;
    if (!ok || a !== (first_ls ? 32'h8000_0100 : 32'h8000_0200)) begin
      errors++; $display("FAIL sim_second_addr: ok=%b addr=%h want %h", ok, a, first_ls ? 32'h8000_0100 : 32'h8000_0200);
    end
    checks++;
    if ({ls_done_o, if_rvalid_o, if_rdata_o} !== {!first_ls, first_ls, 64'hBBBB_0000_BBBB_0002}) begin
      errors++; $display("FAIL sim_second_done: ls_done=%b if_rvalid=%b data=%h", ls_done_o, if_rvalid_o, if_rdata_o);
    end
    idle_inputs();
  endtask

  task automatic test_input_change();
    tick();
    ls_req_i = 1; ls_we_i = 1; ls_addr_i = 32'h8000_0040; ls_wdata_i = 64'h1234_5678_9ABC_DEF0; ls_wstrb_i = 8'hFF;
    tick();
    ls_addr_i = 32'h8000_0FF8; ls_wdata_i = '1; ls_wstrb_i = 8'h01;
    tick();
    checks++;
    if ({bus.bus_addr_o, bus.bus_wdata_o, bus.bus_wstrb_o} !== {32'h8000_0040, 64'h1234_5678_9ABC_DEF0, 8'hFF}) begin
      errors++; $display("FAIL chg_req: addr=%h wdata=%h strb=%h", bus.bus_addr_o, bus.bus_wdata_o, bus.bus_wstrb_o);
    end
    bus.bus_gnt_i = 1;
    tick();
    bus.bus_gnt_i = 0; ls_addr_i = 32'h8000_0000;
    tick();
    checks++;
    if ({bus.bus_addr_o, bus.bus_wdata_o} !== {32'h8000_0040, 64'h1234_5678_9ABC_DEF0}) begin
      errors++; $display("FAIL chg_resp: addr=%h wdata=%h", bus.bus_addr_o, bus.bus_wdata_o);
    end
    bus.bus_bvalid_i = 1;
    tick();
    bus.bus_bvalid_i = 0;
    checks++;
    if (ls_done_o !== 1'b1) begin
      errors++; $display("FAIL chg_done: done=%b want 1", ls_done_o);
    end
    idle_inputs();
  endtask

  task automatic test_reset_in_resp();
    tick();
    if_req_i = 1; if_addr_i = 32'h8000_0008;
    tick();
    bus.bus_gnt_i = 1;
    tick();
    bus.bus_gnt_i = 0; rst = 1;
    tick();
    checks++;
    if ({bus.bus_req_o, if_rvalid_o, if_rdata_o} !== {2'b00, 64'h0}) begin
      errors++; $display("FAIL rstresp_idle: req=%b rvalid=%b data=%h want 0 0 0", bus.bus_req_o, if_rvalid_o, if_rdata_o);
    end
    rst = 0; if_req_i = 0;
    bus.bus_rvalid_i = 1; bus.bus_rdata_i = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    bus.bus_rvalid_i = 0;
    tick();
    checks++;
    if ({bus.bus_req_o, if_rvalid_o, ls_done_o, if_rdata_o} !== {3'b000, 64'h0}) begin
      errors++; $display("FAIL rstresp_late: req=%b rvalid=%b done=%b data=%h want 0 0 0 0", bus.bus_req_o, if_rvalid_o, ls_done_o, if_rdata_o);
    end
  endtask

  task automatic test_stray();
    bus.bus_rvalid_i = 1; bus.bus_rdata_i = 64'hFFFF_0000_FFFF_0000;
    tick();
    bus.bus_rvalid_i = 0;
    tick();
    checks++;
    if ({bus.bus_req_o, if_rvalid_o, ls_done_o, if_rdata_o} !== {3'b000, 64'h0}) begin
      errors++; $display("FAIL stray_idle: req=%b rvalid=%b done=%b data=%h", bus.bus_req_o, if_rvalid_o, ls_done_o, if_rdata_o);
    end
    if_req_i = 1; if_addr_i = 32'h8000_0010;
    tick();
    bus.bus_gnt_i = 1;
    tick();
    bus.bus_gnt_i = 0; bus.bus_bvalid_i = 1; bus.bus_rdata_i = 64'h1;
    tick();
    bus.bus_bvalid_i = 0;
    tick();
    checks++;
    if ({if_rvalid_o, stall_if, if_rdata_o} !== {2'b01, 64'h0}) begin
      errors++; $display("FAIL stray_bvalid: rvalid=%b stall=%b data=%h want 0 1 0", if_rvalid_o, stall_if, if_rdata_o);
    end
    bus.bus_rvalid_i = 1; bus.bus_rdata_i = 64'h0BAD_CAFE_0000_0042;
    tick();
    bus.bus_rvalid_i = 0;
    checks++;
    if ({if_rvalid_o, if_rdata_o} !== {1'b1, 64'h0BAD_CAFE_0000_0042}) begin
      errors++; $display("FAIL stray_real: rvalid=%b data=%h", if_rvalid_o, if_rdata_o);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] bus_mem [16];
    bit oq[$];
    bit last_ls = 0, prev_if = 0, prev_ls = 0, prev_req = 0, resp_pend = 0;
    bit if_pend = 0, ls_pend = 0, exp_if, exp_ls, win;
    int if_gap = 0, ls_gap = 0, phase = 0, dly = 0, stuck = 0, if_idx = 0, ls_idx = 0, bi;
    logic          tx_we = 0;
    logic [AW-1:0] tx_addr = '0;
    logic [DW-1:0] tx_wdata = '0;
    logic [SW-1:0] tx_wstrb = '0;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = {$urandom, $urandom};
      bus_mem[i] = ref_mem[i];
    end
    idle_inputs();
    rst = 1; tick(); rst = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      exp_if = resp_pend && oq.size() > 0 && !oq[0];
      exp_ls = resp_pend && oq.size() > 0 &&  oq[0];
      checks++;
      if ({if_rvalid_o, ls_done_o} !== {exp_if, exp_ls}) begin
        errors++; $display("FAIL rnd_pulse@%0d: if_rvalid=%b ls_done=%b want %b %b", cyc, if_rvalid_o, ls_done_o, exp_if, exp_ls);
      end
      checks++;
      if ({stall_if, stall_mem} !== {if_pend & ~exp_if, ls_pend & ~exp_ls}) begin
        errors++; $display("FAIL rnd_stall@%0d: got %b want %b", cyc, {stall_if, stall_mem}, {if_pend & ~exp_if, ls_pend & ~exp_ls});
      end
      if (resp_pend) begin
        if (oq.size() > 0) void'(oq.pop_front());
        resp_pend = 0;
      end
      if (exp_if) begin
        checks++;
        if (if_rdata_o !== ref_mem[if_idx]) begin
          errors++; $display("FAIL rnd_if_data@%0d: got %h want %h", cyc, if_rdata_o, ref_mem[if_idx]);
        end
        if_req_i = 0; if_pend = 0; if_gap = $urandom_range(0, 3); stuck = 0;
      end
      if (exp_ls) begin
        if (ls_we_i) begin
          for (int b = 0; b < SW; b++) if (ls_wstrb_i[b]) ref_mem[ls_idx][8*b +: 8] = ls_wdata_i[8*b +: 8];
        end else begin
          checks++;
          if (ls_rdata_o !== ref_mem[ls_idx]) begin
            errors++; $display("FAIL rnd_ls_data@%0d: got %h want %h", cyc, ls_rdata_o, ref_mem[ls_idx]);
          end
        end
        ls_req_i = 0; ls_pend = 0; ls_gap = $urandom_range(0, 3); stuck = 0;
      end
      if (bus.bus_req_o && !prev_req) begin
        win = (prev_if && prev_ls) ? (FAIR ? !last_ls : 1'b1) : prev_ls;
        last_ls = win;
        oq.push_back(win);
        tx_we = bus.bus_we_o; tx_addr = bus.bus_addr_o; tx_wdata = bus.bus_wdata_o; tx_wstrb = bus.bus_wstrb_o;
        checks++;
        if (win ? ({tx_we, tx_addr, tx_wdata, tx_wstrb} !== {ls_we_i, ls_addr_i, ls_wdata_i, ls_wstrb_i})
                : ({tx_we, tx_addr, tx_wstrb} !== {1'b0, if_addr_i, 8'h00})) begin
          errors++; $display("FAIL rnd_fields@%0d: owner_ls=%b we=%b addr=%h strb=%h", cyc, win, tx_we, tx_addr, tx_wstrb);
        end
        phase = 1; dly = $urandom_range(0, 3);
      end else if (bus.bus_req_o) begin
        checks++;
        if ({bus.bus_we_o, bus.bus_addr_o, bus.bus_wdata_o, bus.bus_wstrb_o} !== {tx_we, tx_addr, tx_wdata, tx_wstrb}) begin
          errors++; $display("FAIL rnd_stable@%0d: addr=%h want %h", cyc, bus.bus_addr_o, tx_addr);
        end
      end
      prev_req = bus.bus_req_o;
      bus.bus_gnt_i = 0; bus.bus_rvalid_i = 0; bus.bus_bvalid_i = 0;
      case (phase)
        1: if (dly == 0) begin bus.bus_gnt_i = 1; phase = 2; dly = $urandom_range(0, 3); end
           else dly--;
        2: if (dly == 0) begin
             bi = int'(tx_addr[6:3]);
             if (tx_we) begin
               for (int b = 0; b < SW; b++) if (tx_wstrb[b]) bus_mem[bi][8*b +: 8] = tx_wdata[8*b +: 8];
               bus.bus_bvalid_i = 1;
             end else begin
               bus.bus_rvalid_i = 1; bus.bus_rdata_i = bus_mem[bi];
             end
             resp_pend = 1; phase = 0;
           end else begin
             dly--;
             // mismatched response type while waiting must be ignored
             if (tx_we) begin bus.bus_rvalid_i = $urandom_range(0, 1); bus.bus_rdata_i = {$urandom, $urandom}; end
             else bus.bus_bvalid_i = $urandom_range(0, 1);
           end
        default: if ($urandom_range(0, 7) == 0) begin bus.bus_rvalid_i = 1; bus.bus_rdata_i = {$urandom, $urandom}; end
      endcase
      if (!if_pend && cyc < 2800) begin
        if (if_gap > 0) if_gap--;
        else if ($urandom_range(0, 1) == 1) begin
          if_idx = $urandom_range(0, 15); if_addr_i = 32'h8000_0000 + 32'(if_idx * 8);
          if_req_i = 1; if_pend = 1;
        end
      end
      if (!ls_pend && cyc < 2800) begin
        if (ls_gap > 0) ls_gap--;
        else if ($urandom_range(0, 1) == 1) begin
          ls_idx = $urandom_range(0, 15); ls_addr_i = 32'h8000_0000 + 32'(ls_idx * 8);
          ls_we_i = $urandom_range(0, 1); ls_wdata_i = {$urandom, $urandom}; ls_wstrb_i = 8'($urandom);
          ls_req_i = 1; ls_pend = 1;
        end
      end
      prev_if = if_req_i; prev_ls = ls_req_i;
      if (if_pend || ls_pend) stuck++; else stuck = 0;
      if (stuck > 60) begin
        errors++; $display("FAIL rnd_timeout@%0d: no completion for %0d cycles", cyc, stuck);
        break;
      end
    end
    checks++;
    if (if_pend || ls_pend || oq.size() != 0) begin
      errors++; $display("FAIL rnd_drain: if_pend=%b ls_pend=%b outstanding=%0d want 0 0 0", if_pend, ls_pend, oq.size());
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_ls_write();
    test_simultaneous();
    test_input_change();
    test_reset_in_resp();
    test_stray();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
